gpu_alu_sched: RTL and testbench

//   Round-robin scheduler that time-shares one combinational gpu_alu among NUM_REQ requesters.
//   - Accepts one op at a time (opcode plus two operands) over a valid/ready handshake.
//   - Drives the shared ALU for an opcode-dependent number of cycles, then captures result and flags.
//   - Returns the result to the originating requester over a valid/ready handshake.
//   - Sits between the per-lane issue logic and the single shared ALU instance.

---
 rtl/gpu_alu_sched.sv | 183 ++++++++++++++++++
 tb/tb_gpu_alu_sched.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_alu_sched.sv
// Round-robin scheduler time-sharing one combinational ALU among NUM_REQ requesters.
// One op in flight: accept (IDLE) -> drive ALU for an opcode-dependent count (EXEC) -> return (RESP).
module gpu_alu_sched #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_W     = 32,
   parameter int OPC_W      = 6,
   parameter int MUL_CYCLES = 2,
   parameter int DIV_CYCLES = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*OPC_W-1:0]  req_opc,
   input  logic [NUM_REQ*DATA_W-1:0] req_in1,
   input  logic [NUM_REQ*DATA_W-1:0] req_in2,
   output logic [NUM_REQ-1:0]        resp_valid,
   input  logic [NUM_REQ-1:0]        resp_ready,
   output logic [DATA_W-1:0]         resp_data,
   output logic [3:0]                resp_flags,
   output logic                      resp_err,
   output logic [OPC_W-1:0]          alu_opc,
   output logic [DATA_W-1:0]         alu_in1,
   output logic [DATA_W-1:0]         alu_in2,
   input  logic [DATA_W-1:0]         alu_out,
   input  logic [3:0]                alu_flags,
   output logic                      busy
);

   localparam int GW    = $clog2(NUM_REQ);
   localparam int MAX_L = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W = (MAX_L > 1) ? $clog2(MAX_L) : 1;

   localparam logic [OPC_W-1:0] OPC_MUL = OPC_W'(2);
   localparam logic [OPC_W-1:0] OPC_DIV = OPC_W'(3);
   localparam logic [OPC_W-1:0] OPC_MAX = OPC_W'(13);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              state_reg, state_next;
   logic [GW-1:0]       last_grant_reg, last_grant_next;
   logic [GW-1:0]       grant_reg, grant_next;
   logic [OPC_W-1:0]    opc_reg, opc_next;
   logic [DATA_W-1:0]   in1_reg, in1_next;
   logic [DATA_W-1:0]   in2_reg, in2_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic [DATA_W-1:0]   data_reg, data_next;
   logic [3:0]          flags_reg, flags_next;
   logic                err_reg, err_next;

   logic [GW-1:0]       scan_idx;
   logic [GW-1:0]       grant_idx;
   logic                grant_found;
   logic [OPC_W-1:0]    sel_opc;

   // EXEC cycles minus one; every legal opcode other than mul/div is single-cycle.
   function automatic logic [CNT_W-1:0] lat_m1(input logic [OPC_W-1:0] o);
      if (o == OPC_MUL)
         return CNT_W'(MUL_CYCLES - 1);
      else if (o == OPC_DIV)
         return CNT_W'(DIV_CYCLES - 1);
      else
         return '0;
   endfunction

   // Round-robin scan starting just after the last grant, wrapping at NUM_REQ.
   always_comb begin
      scan_idx    = last_grant_reg;
      grant_idx   = '0;
      grant_found = 1'b0;
      for (int off = 0; off < NUM_REQ; off++) begin
         scan_idx = (scan_idx == GW'(NUM_REQ - 1)) ? '0 : scan_idx + 1'b1;
         if (!grant_found && req_valid[scan_idx]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx;
         end
      end
   end

   assign sel_opc = req_opc[grant_idx*OPC_W +: OPC_W];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
         assign req_ready[gi]  = (state_reg == IDLE) && grant_found && (grant_idx == GW'(gi));
         assign resp_valid[gi] = (state_reg == RESP) && (grant_reg == GW'(gi));
      end
   endgenerate

   assign busy       = (state_reg != IDLE);
   assign alu_opc    = opc_reg;
   assign alu_in1    = in1_reg;
   assign alu_in2    = in2_reg;
   assign resp_data  = data_reg;
   assign resp_flags = flags_reg;
   assign resp_err   = err_reg;

   always_comb begin
      state_next      = state_reg;
      last_grant_next = last_grant_reg;
      grant_next      = grant_reg;
      opc_next        = opc_reg;
      in1_next        = in1_reg;
      in2_next        = in2_reg;
      cnt_next        = cnt_reg;
      data_next       = data_reg;
      flags_next      = flags_reg;
      err_next        = err_reg;
      case (state_reg)
         IDLE: begin
            if (grant_found) begin
               grant_next      = grant_idx;
               last_grant_next = grant_idx;
               opc_next        = sel_opc;
               in1_next        = req_in1[grant_idx*DATA_W +: DATA_W];
               in2_next        = req_in2[grant_idx*DATA_W +: DATA_W];
               cnt_next        = lat_m1(sel_opc);
               if (sel_opc > OPC_MAX) begin
                  // Illegal op never touches the ALU result.
                  data_next  = '0;
                  flags_next = 4'b0000;
                  err_next   = 1'b1;
                  state_next = RESP;
               end else begin
                  state_next = EXEC;
               end
            end
         end
         EXEC: begin
            if (cnt_reg == '0) begin
               if (opc_reg == OPC_DIV && in2_reg == '0) begin
                  data_next  = '1;
                  flags_next = 4'b0000;
                  err_next   = 1'b1;
               end else begin
                  data_next  = alu_out;
                  flags_next = alu_flags;
                  err_next   = 1'b0;
               end
               state_next = RESP;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         RESP: begin
            if (resp_ready[grant_reg])
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         last_grant_reg <= GW'(NUM_REQ - 1);
         grant_reg      <= '0;
         opc_reg        <= '0;
         in1_reg        <= '0;
         in2_reg        <= '0;
         cnt_reg        <= '0;
         data_reg       <= '0;
         flags_reg      <= 4'b0000;
         err_reg        <= 1'b0;
      end else begin
         state_reg      <= state_next;
         last_grant_reg <= last_grant_next;
         grant_reg      <= grant_next;
         opc_reg        <= opc_next;
         in1_reg        <= in1_next;
         in2_reg        <= in2_next;
         cnt_reg        <= cnt_next;
         data_reg       <= data_next;
         flags_reg      <= flags_next;
         err_reg        <= err_next;
      end
   end

endmodule

// File: tb/tb_gpu_alu_sched.sv
// Bench for gpu_alu_sched: directed op table plus round-robin, stall and mid-op reset sequences.
module tb_gpu_alu_sched;

   logic          clk;
   logic          rst;
   logic [3:0]    req_valid;
   logic [3:0]    req_ready;
   logic [23:0]   req_opc;
   logic [127:0]  req_in1;
   logic [127:0]  req_in2;
   logic [3:0]    resp_valid;
   logic [3:0]    resp_ready;
   logic [31:0]   resp_data;
   logic [3:0]    resp_flags;
   logic          resp_err;
   logic [5:0]    alu_opc;
   logic [31:0]   alu_in1;
   logic [31:0]   alu_in2;
   logic [31:0]   alu_out;
   logic [3:0]    alu_flags;
   logic          busy;

   int errors = 0;
   int checks = 0;

   gpu_alu_sched #(
      .NUM_REQ(4), .DATA_W(32), .OPC_W(6), .MUL_CYCLES(2), .DIV_CYCLES(8)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_opc(req_opc), .req_in1(req_in1), .req_in2(req_in2),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_flags(resp_flags), .resp_err(resp_err),
      .alu_opc(alu_opc), .alu_in1(alu_in1), .alu_in2(alu_in2),
      .alu_out(alu_out), .alu_flags(alu_flags), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in shared ALU; divide-by-zero returns junk with carry set so overriding is visible.
   logic [32:0] sum;
   logic        alu_c;
   always_comb begin
      sum   = {1'b0, alu_in1} + {1'b0, alu_in2};
      alu_c = 1'b0;
      case (alu_opc)
         6'd0: begin alu_out = sum[31:0]; alu_c = sum[32]; end
         6'd1: alu_out = alu_in1 - alu_in2;
         6'd2: alu_out = alu_in1 * alu_in2;
         6'd3: begin
            if (alu_in2 == 32'd0) begin alu_out = 32'h1234_5678; alu_c = 1'b1; end
            else alu_out = alu_in1 / alu_in2;
         end
         6'd4: alu_out = alu_in1 & alu_in2;
         6'd5: alu_out = alu_in1 | alu_in2;
         6'd6: alu_out = alu_in1 ^ alu_in2;
         default: alu_out = alu_in1;
      endcase
      alu_flags = {alu_out == 32'd0, alu_out[31], 1'b0, alu_c};
   end

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic set_req(input int r, input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
      req_opc[r*6 +: 6]  = o;
      req_in1[r*32 +: 32] = a;
      req_in2[r*32 +: 32] = b;
   endtask

   // Single op from one requester with immediate resp_ready after resp_valid is seen.
   task automatic do_op(input int r, input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] ed, input logic [3:0] ef, input logic ee);
      int n;
      logic [3:0] oh;
      oh = 4'b0001 << r;
      @(negedge clk);
      set_req(r, o, a, b);
      req_valid  = oh;
      resp_ready = 4'b0000;
      #1 check("grant", {28'd0, req_ready}, {28'd0, oh});
      @(negedge clk);
      req_valid = 4'b0000;
      set_req(r, 6'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      check("busy_after_accept", {31'd0, busy}, 32'd1);
      n = 1;
      while (resp_valid == 4'b0000 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("latency", n, lat);
      check("resp_valid", {28'd0, resp_valid}, {28'd0, oh});
      check("resp_data", resp_data, ed);
      check("resp_flags", {28'd0, resp_flags}, {28'd0, ef});
      check("resp_err", {31'd0, resp_err}, {31'd0, ee});
      $display("op r=%0d opc=%0d in1=%h in2=%h cycles=%0d data=%h flags=%b err=%b",
               r, o, a, b, n, resp_data, resp_flags, resp_err);
      resp_ready = oh;
      @(negedge clk);
      check("resp_valid_drop", {28'd0, resp_valid}, 32'd0);
      check("idle_after_hs", {31'd0, busy}, 32'd0);
      resp_ready = 4'b0000;
   endtask

   typedef struct {
      int          r;
      logic [5:0]  opc;
      logic [31:0] in1;
      logic [31:0] in2;
      int          lat;
      logic [31:0] data;
      logic [3:0]  flags;
      logic        err;
   } vec_t;

   localparam int NV = 10;
   vec_t vecs [NV];

   initial begin
      vecs[0] = '{0, 6'd0,  32'd5,         32'd7, 2, 32'd12,        4'b0000, 1'b0};
      vecs[1] = '{1, 6'd1,  32'd5,         32'd7, 2, 32'hFFFF_FFFE, 4'b0100, 1'b0};
      vecs[2] = '{2, 6'd2,  32'd6,         32'd7, 3, 32'd42,        4'b0000, 1'b0};
      vecs[3] = '{2, 6'd3,  32'd100,       32'd7, 9, 32'd14,        4'b0000, 1'b0};
      vecs[4] = '{2, 6'd3,  32'd100,       32'd0, 9, 32'hFFFF_FFFF, 4'b0000, 1'b1};
      vecs[5] = '{1, 6'd20, 32'd99,        32'd1, 1, 32'd0,         4'b0000, 1'b1};
      vecs[6] = '{3, 6'd0,  32'hFFFF_FFFF, 32'd1, 2, 32'd0,         4'b1001, 1'b0};
      vecs[7] = '{0, 6'd13, 32'd0,         32'd3, 2, 32'd0,         4'b1000, 1'b0};
      vecs[8] = '{3, 6'd14, 32'd77,        32'd3, 1, 32'd0,         4'b0000, 1'b1};
      vecs[9] = '{0, 6'd63, 32'd55,        32'd3, 1, 32'd0,         4'b0000, 1'b1};

      rst        = 1'b1;
      req_valid  = 4'b0000;
      resp_ready = 4'b0000;
      req_opc    = '0;
      req_in1    = '0;
      req_in2    = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_resp_valid", {28'd0, resp_valid}, 32'd0);
      check("rst_req_ready", {28'd0, req_ready}, 32'd0);
      check("rst_alu_opc", {26'd0, alu_opc}, 32'd0);
      check("rst_resp_data", resp_data, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < NV; i++)
         do_op(vecs[i].r, vecs[i].opc, vecs[i].in1, vecs[i].in2,
               vecs[i].lat, vecs[i].data, vecs[i].flags, vecs[i].err);

      // All four requesters valid: grants rotate 0,1,2,3,0, one every 3 cycles.
      // The last table grant went to requester 0, so requester 1 leads; force 0 first by rst.
      @(negedge clk);
      rst = 1'b1;
      #1 rst = 1'b0;
      for (int i = 0; i < 4; i++) set_req(i, 6'd0, 32'(10 * i), 32'd1);
      req_valid  = 4'b1111;
      resp_ready = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         int g;
         g = k % 4;
         #1 check("rr_grant", {28'd0, req_ready}, 32'd1 << g);
         @(negedge clk);
         check("rr_busy", {31'd0, busy}, 32'd1);
         @(negedge clk);
         check("rr_resp_valid", {28'd0, resp_valid}, 32'd1 << g);
         check("rr_data", resp_data, 32'(10 * g + 1));
         $display("rr k=%0d grant=%0d data=%0d", k, g, resp_data);
         if (k == 4) req_valid = 4'b0000;
         @(negedge clk);
      end
      resp_ready = 4'b0000;

      // Response stall: outputs hold, foreign resp_ready ignored, requester 3 waits.
      @(negedge clk);
      set_req(0, 6'd0, 32'd1, 32'd2);
      req_valid = 4'b0001;
      #1 check("stall_grant0", {28'd0, req_ready}, 32'b0001);
      @(negedge clk);
      set_req(3, 6'd0, 32'd3, 32'd4);
      req_valid = 4'b1000;
      #1 check("stall_exec_ready", {28'd0, req_ready}, 32'd0);
      @(negedge clk);
      check("stall_resp_valid", {28'd0, resp_valid}, 32'b0001);
      resp_ready = 4'b1110;
      repeat (5) begin
         @(negedge clk);
         #1;
         check("stall_hold_valid", {28'd0, resp_valid}, 32'b0001);
         check("stall_hold_data", resp_data, 32'd3);
         check("stall_busy", {31'd0, busy}, 32'd1);
         check("stall_req_ready", {28'd0, req_ready}, 32'd0);
      end
      $display("stall r=0 data=%0d held 5 cycles", resp_data);
      resp_ready = 4'b0001;
      @(negedge clk);
      resp_ready = 4'b0000;
      #1 check("stall_next_grant", {28'd0, req_ready}, 32'b1000);
      check("stall_valid_drop", {28'd0, resp_valid}, 32'd0);
      @(negedge clk);
      req_valid = 4'b0000;
      @(negedge clk);
      check("stall_r3_valid", {28'd0, resp_valid}, 32'b1000);
      check("stall_r3_data", resp_data, 32'd7);
      $display("stall r=3 data=%0d", resp_data);
      resp_ready = 4'b1000;
      @(negedge clk);
      resp_ready = 4'b0000;

      // Reset in the middle of a divide: immediate clear, no response, pointer back to 3.
      set_req(0, 6'd3, 32'd100, 32'd5);
      req_valid = 4'b0001;
      #1 check("rst_div_grant", {28'd0, req_ready}, 32'b0001);
      @(negedge clk);
      req_valid = 4'b0000;
      repeat (3) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_alu_opc", {26'd0, alu_opc}, 32'd0);
      check("midrst_alu_in1", alu_in1, 32'd0);
      check("midrst_alu_in2", alu_in2, 32'd0);
      repeat (10) begin
         @(negedge clk);
         check("midrst_no_resp", {28'd0, resp_valid}, 32'd0);
      end
      rst = 1'b0;
      set_req(0, 6'd0, 32'd8, 32'd8);
      set_req(3, 6'd0, 32'd1, 32'd1);
      req_valid = 4'b1001;
      #1 check("midrst_first_grant", {28'd0, req_ready}, 32'b0001);
      @(negedge clk);
      req_valid = 4'b0000;
      @(negedge clk);
      check("midrst_resp_valid", {28'd0, resp_valid}, 32'b0001);
      check("midrst_resp_data", resp_data, 32'd16);
      $display("post-reset r=0 data=%0d", resp_data);
      resp_ready = 4'b0001;
      @(negedge clk);
      resp_ready = 4'b0000;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
